pair_turn_sequencer: RTL and testbench
======================================

Name: pair_turn_sequencer

Overview:
- Turn controller for the 8-square colour matching game.
- Sequences the pick steps, latches the two squares picked per turn, and compares their colours after a timed reveal.
- Maintains the matched-square mask, match and miss counters, and the win/lose flags.
- Drives the step code consumed by the per-step cursor modules; receives their cursor position and the board colour map.

Parameters:
- SHOW_CYCLES, 25_000_000, reveal hold time in clk25MHz cycles (1 s); legal range ≥ 2.
- NUM_PAIRS, 4, number of colour pairs on the board (8 squares); fixed at 4 in this version.
- MAX_MISS, 7, miss limit; used only when MISS_LIMIT_EN is defined.

Ports:
- clk25MHz  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a game from IDLE or from a finished game.
- confirm  in  1  one-cycle pulse, already debounced; accepts the current cursor square.
- cursor  in  3  square index the active step module currently points at.
- color_map  in  24  packed colour per square; square k = color_map[3k+2:3k].
- step  out  4  active step code for the cursor modules.
- pick_a  out  3  first square picked this turn.
- pick_b  out  3  second square picked this turn.
- reveal  out  1  high while both picks are shown.
- matched  out  8  bit k set = square k permanently matched.
- match_cnt  out  3  pairs found, 0..4.
- miss_cnt  out  4  failed turns, saturates at 15.
- win  out  1  level; all pairs found.
- lose  out  1  level; miss limit reached (MISS_LIMIT_EN only, else tied 0).

Behaviour:
- Clock: one clock, clk25MHz. Reset: rst_n is asynchronous and active-low.
- Reset values: state=IDLE, step=0, pick_a=0, pick_b=0, reveal=0, matched=0, match_cnt=0, miss_cnt=0, win=0, lose=0, show timer=0.
- States: IDLE, PICK_A, PICK_B, SHOW, JUDGE, DONE.
- IDLE -> PICK_A on start. Entry clears matched, both counters, win and lose.
- PICK_A:
  - step = 2*match_cnt+1.
  - On confirm with matched[cursor]=0: pick_a<=cursor, go to PICK_B.
  - Confirm on a matched square is ignored; state is unchanged.
- PICK_B:
  - step = 2*match_cnt+2.
  - On confirm with matched[cursor]=0 and cursor≠pick_a: pick_b<=cursor, timer<=0, reveal<=1, go to SHOW.
  - Any other confirm is ignored.
- SHOW:
  - Timer increments every cycle.
  - On timer==SHOW_CYCLES-1: reveal<=0, go to JUDGE.
  - Reveal is high for exactly SHOW_CYCLES cycles.
  - confirm and start are ignored.
- JUDGE (single cycle):
  - Colour of pick_a == colour of pick_b: set matched[pick_a] and matched[pick_b], match_cnt+1.
  - Otherwise: miss_cnt+1, saturating at 15.
  - Next state: DONE with win<=1 if the post-increment match_cnt==NUM_PAIRS; else PICK_A.
- DONE:
  - step=4'hF; outputs hold.
  - start re-enters PICK_A with a full clear, same as from IDLE.
- step=0 in IDLE. During SHOW and JUDGE, step keeps its PICK_B value.
- Simultaneous confirm and start in PICK_A or PICK_B: start has no effect; confirm is processed.
- Counter and mask updates are registered; the new values are visible in the cycle after JUDGE.
- Reset asserted mid-SHOW: reveal drops immediately (asynchronous); all state clears.

Optional Feature:
- Macro: MISS_LIMIT_EN.
- Defined:
  - In JUDGE, a miss whose post-increment miss_cnt==MAX_MISS sets lose<=1 and goes to DONE.
  - If the same judge also completes the board, win takes priority.
- Undefined: lose is constant 0, there is no miss limit, and miss_cnt only saturates.

Decomposition:
- Shared package game_pkg holds:
  - square index constants kare0..kare7;
  - state encoding;
  - STEP_IDLE=0 and STEP_DONE=4'hF;
  - colour width 3;
  - NUM_SQUARES=8.
- One sub-module: reveal_timer. It is a load/count/terminal-count counter parameterised by SHOW_CYCLES and is reused by the display block.

Test Plan:
- Colour map 0,0,1,1,2,2,3,3 for squares 0..7, start, confirm cursor 0 then 1:
  - reveal high for exactly SHOW_CYCLES cycles (run with SHOW_CYCLES=4);
  - then matched=8'h03, match_cnt=1, step=3.
- Same map, picks 0 then 2: miss_cnt=1, matched=0, back in PICK_A with step=1.
- With matched=8'h03:
  - confirm cursor 1 in PICK_A is ignored; state stays PICK_A.
  - In PICK_B, confirm cursor==pick_a is ignored.
- Match all four pairs: after the fourth JUDGE, win=1 and step=F. A later start clears matched, match_cnt, miss_cnt and win.
- MISS_LIMIT_EN with MAX_MISS=2: two misses give lose=1 and state DONE; without the macro, lose stays 0 and play continues.
- Assert rst_n low in the middle of SHOW: reveal, pick_a, pick_b and matched go to 0 in the same cycle without a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, state encoding and colour helper for the matching game
// Contents: square indices kare0..kare7, FSM state encoding, step codes,
// colour width and square count, plus square_color() to pull one square's
// colour out of the packed board colour map.
package game_pkg;

  localparam int COLOR_W     = 3;
  localparam int NUM_SQUARES = 8;
  localparam int SQ_W        = 3;

  localparam logic [SQ_W-1:0] kare0 = 3'd0;
  localparam logic [SQ_W-1:0] kare1 = 3'd1;
  localparam logic [SQ_W-1:0] kare2 = 3'd2;
  localparam logic [SQ_W-1:0] kare3 = 3'd3;
  localparam logic [SQ_W-1:0] kare4 = 3'd4;
  localparam logic [SQ_W-1:0] kare5 = 3'd5;
  localparam logic [SQ_W-1:0] kare6 = 3'd6;
  localparam logic [SQ_W-1:0] kare7 = 3'd7;

  localparam logic [3:0] STEP_IDLE = 4'h0;
  localparam logic [3:0] STEP_DONE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PICK_A = 3'd1,
    ST_PICK_B = 3'd2,
    ST_SHOW   = 3'd3,
    ST_JUDGE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic logic [COLOR_W-1:0] square_color(
    input logic [NUM_SQUARES*COLOR_W-1:0] map,
    input logic [SQ_W-1:0]                idx
  );
    return map[idx*COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/reveal_timer.sv
// rtl/reveal_timer.sv - load/count/terminal-count counter for the reveal hold time
// Ports:
//   clk25MHz  in   system clock
//   rst_n     in   asynchronous active-low reset
//   load      in   clear the count to 0 (wins over en)
//   en        in   advance the count by one
//   tc        out  count == CYCLES-1
module reveal_timer #(
  parameter int CYCLES = 25_000_000
) (
  input  logic clk25MHz,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(CYCLES);

  logic [W-1:0] count_q;

  assign tc = (count_q == W'(CYCLES - 1));

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en) begin
      // Wrap at terminal count so the counter never walks past CYCLES-1.
      count_q <= tc ? '0 : count_q + W'(1);
    end
  end

endmodule

// File: rtl/pair_turn_sequencer.sv
// rtl/pair_turn_sequencer.sv - turn controller for the 8-square colour matching game
// Optional feature macro: MISS_LIMIT_EN (miss limit MAX_MISS drives lose).
// Ports:
//   clk25MHz   in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse; new game from IDLE or DONE
//   confirm    in   pulse; accept the square under the cursor
//   cursor     in   square index of the active step module
//   color_map  in   packed 3-bit colour per square
//   step       out  active step code for the cursor modules
//   pick_a     out  first square picked this turn
//   pick_b     out  second square picked this turn
//   reveal     out  high while both picks are shown
//   matched    out  permanently matched squares
//   match_cnt  out  pairs found
//   miss_cnt   out  failed turns, saturating at 15
//   win        out  all pairs found
//   lose       out  miss limit reached (0 unless MISS_LIMIT_EN)
module pair_turn_sequencer
  import game_pkg::*;
#(
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int NUM_PAIRS   = 4,
  parameter int MAX_MISS    = 7
) (
  input  logic                           clk25MHz,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           confirm,
  input  logic [SQ_W-1:0]                cursor,
  input  logic [NUM_SQUARES*COLOR_W-1:0] color_map,
  output logic [3:0]                     step,
  output logic [SQ_W-1:0]                pick_a,
  output logic [SQ_W-1:0]                pick_b,
  output logic                           reveal,
  output logic [NUM_SQUARES-1:0]         matched,
  output logic [2:0]                     match_cnt,
  output logic [3:0]                     miss_cnt,
  output logic                           win,
  output logic                           lose
);

`ifdef MISS_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_e state_q, state_d;

  logic [SQ_W-1:0]        pick_a_q, pick_b_q;
  logic                   reveal_q;
  logic [NUM_SQUARES-1:0] matched_q;
  logic [2:0]             match_cnt_q;
  logic [3:0]             miss_cnt_q;
  logic                   win_q, lose_q;

  logic       show_tc;
  logic       new_game, accept_a, accept_b, show_done, judging;
  logic       same_color, board_done, limit_hit;
  logic [2:0] match_post;
  logic [3:0] miss_post;

  // start only acts outside active play; confirm inside play wins by construction.
  assign new_game   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept_a   = (state_q == ST_PICK_A) && confirm && !matched_q[cursor];
  assign accept_b   = (state_q == ST_PICK_B) && confirm && !matched_q[cursor] &&
                      (cursor != pick_a_q);
  assign show_done  = (state_q == ST_SHOW) && show_tc;
  assign judging    = (state_q == ST_JUDGE);

  assign same_color = square_color(color_map, pick_a_q) == square_color(color_map, pick_b_q);
  assign match_post = match_cnt_q + 3'd1;
  assign miss_post  = (miss_cnt_q == 4'hF) ? 4'hF : miss_cnt_q + 4'd1;
  assign board_done = same_color && (match_post == 3'(NUM_PAIRS));
  // A completed board never counts as a miss, so win naturally has priority.
  assign limit_hit  = LIMIT_EN && !same_color && (miss_post == 4'(MAX_MISS));

  reveal_timer #(.CYCLES(SHOW_CYCLES)) u_reveal_timer (
    .clk25MHz (clk25MHz),
    .rst_n    (rst_n),
    .load     (accept_b),
    .en       (state_q == ST_SHOW),
    .tc       (show_tc)
  );

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (new_game)  state_d = ST_PICK_A;
      ST_PICK_A: if (accept_a)  state_d = ST_PICK_B;
      ST_PICK_B: if (accept_b)  state_d = ST_SHOW;
      ST_SHOW:   if (show_done) state_d = ST_JUDGE;
      ST_JUDGE:  state_d = (board_done || limit_hit) ? ST_DONE : ST_PICK_A;
      ST_DONE:   if (new_game)  state_d = ST_PICK_A;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Each pair found advances the cursor modules by two steps.
  always_comb begin
    step = STEP_IDLE;
    unique case (state_q)
      ST_IDLE:                     step = STEP_IDLE;
      ST_PICK_A:                   step = {match_cnt_q, 1'b0} + 4'd1;
      ST_PICK_B, ST_SHOW, ST_JUDGE: step = {match_cnt_q, 1'b0} + 4'd2;
      ST_DONE:                     step = STEP_DONE;
      default:                     step = STEP_IDLE;
    endcase
  end

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pick_a_q    <= '0;
      pick_b_q    <= '0;
      reveal_q    <= 1'b0;
      matched_q   <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      if (new_game) begin
        matched_q   <= '0;
        match_cnt_q <= '0;
        miss_cnt_q  <= '0;
        win_q       <= 1'b0;
        lose_q      <= 1'b0;
      end
      if (accept_a) pick_a_q <= cursor;
      if (accept_b) begin
        pick_b_q <= cursor;
        reveal_q <= 1'b1;
      end
      if (show_done) reveal_q <= 1'b0;
      if (judging) begin
        if (same_color) begin
          matched_q   <= matched_q | (NUM_SQUARES'(1) << pick_a_q) | (NUM_SQUARES'(1) << pick_b_q);
          match_cnt_q <= match_post;
          if (board_done) win_q <= 1'b1;
        end else begin
          miss_cnt_q <= miss_post;
          if (limit_hit) lose_q <= 1'b1;
        end
      end
    end
  end

  assign pick_a    = pick_a_q;
  assign pick_b    = pick_b_q;
  assign reveal    = reveal_q;
  assign matched   = matched_q;
  assign match_cnt = match_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_pair_turn_sequencer.sv
// tb/tb_pair_turn_sequencer.sv - self-checking bench for pair_turn_sequencer
module tb_pair_turn_sequencer;

  localparam int SHOW_CYCLES = 4;
  localparam int MAX_MISS    = 2;

`ifdef MISS_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic        clk25MHz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        confirm  = 1'b0;
  logic [2:0]  cursor   = 3'd0;
  logic [23:0] color_map;
  logic [3:0]  step;
  logic [2:0]  pick_a, pick_b;
  logic        reveal;
  logic [7:0]  matched;
  logic [2:0]  match_cnt;
  logic [3:0]  miss_cnt;
  logic        win, lose;

  always #20 clk25MHz = ~clk25MHz;

  pair_turn_sequencer #(
    .SHOW_CYCLES (SHOW_CYCLES),
    .NUM_PAIRS   (4),
    .MAX_MISS    (MAX_MISS)
  ) dut (
    .clk25MHz  (clk25MHz),
    .rst_n     (rst_n),
    .start     (start),
    .confirm   (confirm),
    .cursor    (cursor),
    .color_map (color_map),
    .step      (step),
    .pick_a    (pick_a),
    .pick_b    (pick_b),
    .reveal    (reveal),
    .matched   (matched),
    .match_cnt (match_cnt),
    .miss_cnt  (miss_cnt),
    .win       (win),
    .lose      (lose)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int col [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  // Model: phase names, picks, found-square set, counts, remaining reveal cycles.
  localparam int P_IDLE = 0, P_A = 1, P_B = 2, P_SHOW = 3, P_JUDGE = 4, P_DONE = 5;
  int       m_ph, m_pa, m_pb, m_left, m_mc, m_miss;
  bit [7:0] m_mask;
  bit       m_win, m_lose;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int m_step();
    case (m_ph)
      P_IDLE:  return 0;
      P_A:     return 2 * m_mc + 1;
      P_DONE:  return 15;
      default: return 2 * m_mc + 2;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_pa = 0; m_pb = 0; m_left = 0; m_mc = 0; m_miss = 0;
    m_mask = '0; m_win = 0; m_lose = 0;
  endtask

  task automatic model_clock(input bit s, input bit c, input int cur);
    case (m_ph)
      P_IDLE, P_DONE: if (s) begin
        m_mask = '0; m_mc = 0; m_miss = 0; m_win = 0; m_lose = 0; m_ph = P_A;
      end
      P_A: if (c && !m_mask[cur]) begin
        m_pa = cur; m_ph = P_B;
      end
      P_B: if (c && !m_mask[cur] && cur != m_pa) begin
        m_pb = cur; m_left = SHOW_CYCLES; m_ph = P_SHOW;
      end
      P_SHOW: begin
        m_left--;
        if (m_left == 0) m_ph = P_JUDGE;
      end
      P_JUDGE: begin
        m_ph = P_A;
        if (col[m_pa] == col[m_pb]) begin
          m_mask[m_pa] = 1'b1; m_mask[m_pb] = 1'b1; m_mc++;
          if (m_mc == 4) begin m_win = 1; m_ph = P_DONE; end
        end else begin
          if (m_miss < 15) m_miss++;
          if (LIM && m_miss == MAX_MISS) begin m_lose = 1; m_ph = P_DONE; end
        end
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic compare_all();
    chk("step",      step,      m_step());
    chk("pick_a",    pick_a,    m_pa);
    chk("pick_b",    pick_b,    m_pb);
    chk("reveal",    reveal,    (m_ph == P_SHOW) ? 1 : 0);
    chk("matched",   matched,   m_mask);
    chk("match_cnt", match_cnt, m_mc);
    chk("miss_cnt",  miss_cnt,  m_miss);
    chk("win",       win,       m_win);
    chk("lose",      lose,      m_lose);
  endtask

  // Called at a negedge: drive, advance model, clock, compare at next negedge.
  task automatic cyc(input bit s, input bit c, input int cur);
    start   = s;
    confirm = c;
    cursor  = 3'(cur);
    model_clock(s, c, cur);
    @(posedge clk25MHz);
    @(negedge clk25MHz);
    compare_all();
    start   = 1'b0;
    confirm = 1'b0;
  endtask

  task automatic turn(input int a, input int b);
    int rv;
    rv = 0;
    cyc(0, 1, a);
    cyc(0, 1, b);
    if (reveal) rv++;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      if (reveal) rv++;
    end
    chk("reveal_len", rv, SHOW_CYCLES);
  endtask

  initial begin
    logic [2:0] cv;
    for (int k = 0; k < 8; k++) begin
      cv = 3'(col[k]);
      color_map[3*k +: 3] = cv;
    end
    model_reset();
    repeat (2) @(negedge clk25MHz);
    compare_all();
    chk("rst_step", step, 0);
    rst_n = 1'b1;
    cyc(0, 1, 3);
    chk("idle_ignores_confirm", step, 0);

    cyc(1, 0, 0);
    chk("start_step", step, 1);
    turn(0, 2);
    chk("miss1_cnt", miss_cnt, 1);
    chk("miss1_matched", matched, 8'h00);
    chk("miss1_step", step, 1);

    turn(0, 1);
    chk("match1_matched", matched, 8'h03);
    chk("match1_cnt", match_cnt, 1);
    chk("match1_step", step, 3);

    cyc(0, 1, 1);
    chk("ignore_matched_a", step, 3);
    cyc(0, 1, 2);
    chk("pick_b_step", step, 4);
    cyc(0, 1, 2);
    chk("ignore_same_b", step, 4);
    cyc(1, 1, 3);
    chk("start_conf_reveal", reveal, 1);
    chk("start_conf_mc", match_cnt, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    chk("match2_matched", matched, 8'h0F);

    turn(4, 5);
    turn(6, 7);
    chk("win_flag", win, 1);
    chk("win_step", step, 15);
    chk("win_matched", matched, 8'hFF);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("restart_matched", matched, 0);
    chk("restart_mc", match_cnt, 0);
    chk("restart_miss", miss_cnt, 0);
    chk("restart_win", win, 0);
    chk("restart_step", step, 1);

    turn(0, 2);
    turn(0, 2);
`ifdef MISS_LIMIT_EN
    chk("limit_lose", lose, 1);
    chk("limit_step", step, 15);
`else
    chk("nolimit_lose", lose, 0);
    chk("nolimit_step", step, 1);
    chk("nolimit_miss", miss_cnt, 2);
`endif

    cyc(1, 0, 0);
    turn(0, 1);
    cyc(0, 1, 5);
    cyc(0, 1, 6);
    cyc(0, 0, 0);
    chk("pre_rst_reveal", reveal, 1);
    chk("pre_rst_pick_a", pick_a, 5);
    chk("pre_rst_pick_b", pick_b, 6);
    chk("pre_rst_matched", matched, 8'h03);
    #5 rst_n = 1'b0;
    #1;
    chk("async_reveal", reveal, 0);
    chk("async_pick_a", pick_a, 0);
    chk("async_pick_b", pick_b, 0);
    chk("async_matched", matched, 0);
    chk("async_step", step, 0);
    model_reset();
    @(negedge clk25MHz);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    turn(2, 3);
    chk("post_rst_matched", matched, 8'h0C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
